// File: rtl/dnn_sched_pkg.sv
// Shared types and helpers for the DNN training scheduler: FSM state, width helper, LFSR taps.
package dnn_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Width of a counter holding 0..v-1, never narrower than one bit.
    function automatic int clog2c(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Fibonacci feedback masks for maximal-length LFSRs, indexed by register width.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            default: return 16'h0001;
        endcase
    endfunction

endpackage

// File: rtl/dnn_train_scheduler_if.sv
// Handshake/status bundle between the training scheduler and its sample memory / datapath.
interface dnn_train_scheduler_if
    import dnn_sched_pkg::*;
#(
    parameter int CPC       = 6,
    parameter int SAMPLES   = 8,
    parameter int EPOCHS    = 2,
    parameter int N_OUT     = 4,
    parameter int FRAC_BITS = 7
);
    localparam int CW  = clog2c(CPC);
    localparam int AW  = clog2c(SAMPLES);
    localparam int EW  = clog2c(EPOCHS + 1);
    localparam int ETW = clog2c(FRAC_BITS + 1);
    localparam int SCW = clog2c(SAMPLES * EPOCHS + 1);

    logic             start;
    logic             abort;
    logic             mem_rd;
    logic [AW-1:0]    mem_addr;
    logic [CW-1:0]    mem_chunk;
    logic [N_OUT-1:0] label_in;
    logic [N_OUT-1:0] a_out_alln;
    logic             cycle_clk;
    logic [CW-1:0]    cycle_index;
    logic [ETW-1:0]   eta1pos;
    logic             sample_valid;
    logic [EW-1:0]    epoch;
    logic [SCW-1:0]   correct_count;
    logic             busy;
    logic             done;

    modport slave (
        input  start, abort, label_in, a_out_alln,
        output mem_rd, mem_addr, mem_chunk, cycle_clk, cycle_index, eta1pos,
               sample_valid, epoch, correct_count, busy, done
    );

    modport master (
        output start, abort, label_in, a_out_alln,
        input  mem_rd, mem_addr, mem_chunk, cycle_clk, cycle_index, eta1pos,
               sample_valid, epoch, correct_count, busy, done
    );

endinterface

// File: rtl/dnn_label_delay.sv
// Tagged label delay line {valid, label}; advances one entry per shift_en, tail is the oldest.
module dnn_label_delay
    import dnn_sched_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic [W:0]   din,
    output logic [W:0]   tail
);
    logic [DEPTH-1:0][W:0] line_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            line_q <= '0;
        end else if (shift_en) begin
            line_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign tail = line_q[DEPTH-1];

endmodule

// File: rtl/dnn_train_scheduler.sv
// Training sequencer: block timing, per-sample issue, eta decay, pipeline drain and scoring.
// Optional build macro SCHED_LFSR_ORDER_EN permutes sample order per epoch (addr = seq ^ LFSR seed).
module dnn_train_scheduler
    import dnn_sched_pkg::*;
#(
    parameter int CPC              = 6,
    parameter int L                = 3,
    parameter int OUT_LAT          = L,
    parameter int N_OUT            = 4,
    parameter int SAMPLES          = 8,
    parameter int EPOCHS           = 2,
    parameter int FRAC_BITS        = 7,
    parameter int ETA1POS_INIT     = 2,
    parameter int ETA_DECAY_EPOCHS = 1
) (
    input logic                  clk,
    input logic                  reset,
    dnn_train_scheduler_if.slave bus
);
    localparam int CW  = clog2c(CPC);
    localparam int AW  = clog2c(SAMPLES);
    localparam int EW  = clog2c(EPOCHS + 1);
    localparam int ETW = clog2c(FRAC_BITS + 1);
    localparam int SCW = clog2c(SAMPLES * EPOCHS + 1);
    localparam int DW  = clog2c(ETA_DECAY_EPOCHS);
    localparam int DRW = clog2c(OUT_LAT);

    state_e         state_q;
    logic [CW-1:0]  cyc_q;
    logic           sv_q, busy_q, done_q, abort_pend_q;
    logic [AW-1:0]  seq_q, seq_d;
    logic [EW-1:0]  epoch_q, epoch_d;
    logic [ETW-1:0] eta_q, eta_d;
    logic [DW-1:0]  decay_q, decay_d;
    logic [DRW-1:0] drain_q;
    logic [SCW-1:0] correct_q, correct_d;
    logic [N_OUT:0] cap_q, tail;
    logic           blk_end, wrap, last, decay_hit, score_hit;

    always_comb begin
        blk_end   = (cyc_q == CW'(CPC - 1));
        wrap      = (seq_q == AW'(SAMPLES - 1));
        last      = wrap && (epoch_q == EW'(EPOCHS - 1));
        seq_d     = wrap ? '0 : seq_q + AW'(1);
        epoch_d   = epoch_q + (wrap ? EW'(1) : EW'(0));
        decay_hit = wrap && (decay_q == DW'(ETA_DECAY_EPOCHS - 1));
        decay_d   = decay_q;
        if (wrap) decay_d = decay_hit ? '0 : decay_q + DW'(1);
        eta_d     = (decay_hit && eta_q != ETW'(FRAC_BITS)) ? eta_q + ETW'(1) : eta_q;
        // Tail entry belongs to the sample issued OUT_LAT blocks ago; bubbles carry valid=0.
        score_hit = busy_q && (cyc_q == '0) && tail[N_OUT] && (bus.a_out_alln == tail[N_OUT-1:0]);
        correct_d = (score_hit && correct_q != '1) ? correct_q + SCW'(1) : correct_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            sv_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            seq_q        <= '0;
            epoch_q      <= '0;
            eta_q        <= ETW'(ETA1POS_INIT);
            decay_q      <= '0;
            drain_q      <= '0;
            correct_q    <= '0;
            cap_q        <= '0;
        end else begin
            correct_q <= correct_d;
            if (busy_q) cyc_q <= blk_end ? '0 : cyc_q + CW'(1);
            if (busy_q && cyc_q == CW'(1)) cap_q <= {sv_q, bus.label_in};
            if (state_q == RUN && bus.abort) abort_pend_q <= 1'b1;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        cyc_q        <= '0;
                        sv_q         <= 1'b1;
                        seq_q        <= '0;
                        epoch_q      <= '0;
                        eta_q        <= ETW'(ETA1POS_INIT);
                        decay_q      <= '0;
                        correct_q    <= '0;
                        abort_pend_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (blk_end) begin
                        seq_q   <= seq_d;
                        epoch_q <= epoch_d;
                        eta_q   <= eta_d;
                        decay_q <= decay_d;
                        if (last || abort_pend_q || bus.abort) begin
                            state_q      <= DRAIN;
                            sv_q         <= 1'b0;
                            drain_q      <= '0;
                            abort_pend_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (blk_end) begin
                        if (drain_q == DRW'(OUT_LAT - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + DRW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dnn_label_delay #(.DEPTH(OUT_LAT), .W(N_OUT)) u_label_delay (
        .clk      (clk),
        .reset    (reset),
        .shift_en (blk_end),
        .din      (cap_q),
        .tail     (tail)
    );

`ifdef SCHED_LFSR_ORDER_EN
    localparam logic [AW-1:0] TAPS = AW'(lfsr_taps(AW));
    logic [AW-1:0] seed_q, seed_d;

    always_comb begin
        seed_d = seed_q;
        if (wrap) seed_d = AW'({seed_q, ^(seed_q & TAPS)});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seed_q <= AW'(1);
        end else if ((state_q == IDLE || state_q == DONE) && bus.start) begin
            seed_q <= AW'(1);
        end else if (state_q == RUN && blk_end) begin
            seed_q <= seed_d;
        end
    end

    assign bus.mem_addr = sv_q ? (seq_q ^ seed_q) : '0;
`else
    assign bus.mem_addr = seq_q;
`endif

    assign bus.mem_rd        = sv_q && (cyc_q < CW'(CPC - 2));
    assign bus.mem_chunk     = cyc_q;
    assign bus.cycle_clk     = blk_end;
    assign bus.cycle_index   = cyc_q;
    assign bus.eta1pos       = eta_q;
    assign bus.sample_valid  = sv_q;
    assign bus.epoch         = epoch_q;
    assign bus.correct_count = correct_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_dnn_train_scheduler.sv
// Directed bench for dnn_train_scheduler: reset, full runs (echo / wrong labels), abort, eta saturation.
module tb_dnn_train_scheduler;
    import dnn_sched_pkg::*;

    localparam int CPC = 6, SAMPLES = 8, EPOCHS = 2, N_OUT = 4, FRAC_BITS = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dnn_train_scheduler_if #(.CPC(CPC), .SAMPLES(SAMPLES), .EPOCHS(EPOCHS), .N_OUT(N_OUT),
                             .FRAC_BITS(FRAC_BITS)) mif ();
    dnn_train_scheduler_if #(.CPC(CPC), .SAMPLES(SAMPLES), .EPOCHS(EPOCHS), .N_OUT(N_OUT),
                             .FRAC_BITS(FRAC_BITS)) sif ();

    dnn_train_scheduler #(.CPC(CPC), .L(3), .OUT_LAT(3), .N_OUT(N_OUT), .SAMPLES(SAMPLES),
                          .EPOCHS(EPOCHS), .FRAC_BITS(FRAC_BITS), .ETA1POS_INIT(2),
                          .ETA_DECAY_EPOCHS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    // Second instance starting at the eta ceiling; it must never move.
    dnn_train_scheduler #(.CPC(CPC), .L(3), .OUT_LAT(3), .N_OUT(N_OUT), .SAMPLES(SAMPLES),
                          .EPOCHS(EPOCHS), .FRAC_BITS(FRAC_BITS), .ETA1POS_INIT(7),
                          .ETA_DECAY_EPOCHS(1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    assign sif.start      = mif.start;
    assign sif.abort      = mif.abort;
    assign sif.label_in   = '0;
    assign sif.a_out_alln = '0;

    int n_chk = 0;
    int n_err = 0;
    int mode  = 0;   // 0: prediction echoes label, 1: prediction always wrong
    int blk   = 0;
    logic [3:0] hist [0:31];
    logic [3:0] lbl;

    // Sample memory: one-hot label of the address, returned one clock after the chunk-0 read.
    always_comb lbl = (mode == 1) ? 4'b0010 : (4'b0001 << mif.mem_addr[1:0]);

    always @(posedge clk) begin
        if (mif.mem_rd && mif.mem_chunk == 0) begin
            mif.label_in <= lbl;
            if (blk < 32) hist[blk] <= lbl;
        end else begin
            mif.label_in <= '0;
        end
        if (mif.start && !mif.busy) blk <= 0;
        else if (mif.cycle_clk) blk <= blk + 1;
    end

    always_comb begin
        mif.a_out_alln = 4'b0000;
        if (mode == 1) mif.a_out_alln = 4'b0001;
        else if (blk >= 3 && blk < 35) mif.a_out_alln = hist[blk-3];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int b);
`ifdef SCHED_LFSR_ORDER_EN
        return (b % 8) ^ ((b < 8) ? 1 : 2);
`else
        return b % 8;
`endif
    endfunction

    task automatic check_idle_after_reset(input string tag);
        chk({tag, "_busy"}, int'(mif.busy), 0);
        chk({tag, "_done"}, int'(mif.done), 0);
        chk({tag, "_rd"},   int'(mif.mem_rd), 0);
        chk({tag, "_idx"},  int'(mif.cycle_index), 0);
        chk({tag, "_eta"},  int'(mif.eta1pos), 2);
        chk({tag, "_cnt"},  int'(mif.correct_count), 0);
        chk({tag, "_ep"},   int'(mif.epoch), 0);
        chk({tag, "_sv"},   int'(mif.sample_valid), 0);
    endtask

    task automatic run(input int nrun, input int abort_blk, input int exp_cnt, input int exp_ep);
        int rd_cnt, idx_err, clk_err, sv, addr, eta, eta_s;
        logic [7:0] seen [0:1];
        seen[0] = 8'h00;
        seen[1] = 8'h00;
        @(negedge clk); mif.start = 1'b1;
        @(negedge clk); mif.start = 1'b0;
        chk("entry_done", int'(mif.done), 0);
        chk("entry_cnt", int'(mif.correct_count), 0);
        for (int b = 0; b < nrun + 3; b++) begin
            rd_cnt = 0; idx_err = 0; clk_err = 0;
            sv = 0; addr = 0; eta = 0; eta_s = 0;
            for (int c = 0; c < CPC; c++) begin
                mif.abort = (b == abort_blk && c == 2);
                mif.start = (b == 3 && c == 1);
                if (c == 0) begin
                    sv = int'(mif.sample_valid); addr = int'(mif.mem_addr);
                    eta = int'(mif.eta1pos); eta_s = int'(sif.eta1pos);
                end
                if (int'(mif.cycle_index) != c) idx_err++;
                if (mif.cycle_clk != (c == CPC - 1)) clk_err++;
                if (mif.mem_rd) begin
                    rd_cnt++;
                    if (int'(mif.mem_chunk) != c) idx_err++;
                end
                if (sv == 1 && int'(mif.mem_addr) != addr) idx_err++;
                @(negedge clk);
            end
            mif.abort = 1'b0;
            mif.start = 1'b0;
            if (b < nrun) begin
                chk($sformatf("sv_b%0d", b), sv, 1);
                chk($sformatf("addr_b%0d", b), addr, exp_addr(b));
                chk($sformatf("eta_b%0d", b), eta, (b < 8) ? 2 : 3);
                chk($sformatf("eta_sat_b%0d", b), eta_s, 7);
                chk($sformatf("rd_b%0d", b), rd_cnt, CPC - 2);
                seen[b / 8][addr] = 1'b1;
            end else begin
                chk($sformatf("drain_sv_b%0d", b), sv, 0);
                chk($sformatf("drain_rd_b%0d", b), rd_cnt, 0);
            end
            chk($sformatf("idx_b%0d", b), idx_err, 0);
            chk($sformatf("cycclk_b%0d", b), clk_err, 0);
        end
`ifdef SCHED_LFSR_ORDER_EN
        if (nrun == 16) begin
            chk("perm_ep0", int'(seen[0]), 255);
            chk("perm_ep1", int'(seen[1]), 255);
        end
`endif
        chk("end_done", int'(mif.done), 1);
        chk("end_busy", int'(mif.busy), 0);
        chk("end_idx", int'(mif.cycle_index), 0);
        chk("end_rd", int'(mif.mem_rd), 0);
        chk("end_cnt", int'(mif.correct_count), exp_cnt);
        chk("end_ep", int'(mif.epoch), exp_ep);
        chk("end_sat_done", int'(sif.done), 1);
    endtask

    initial begin
        mif.start = 1'b0;
        mif.abort = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_idle_after_reset("rst");

        // Reset in the middle of a run discards it.
        @(negedge clk); mif.start = 1'b1;
        @(negedge clk); mif.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", int'(mif.busy), 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_idle_after_reset("midrst");

        mode = 0;
        run(16, -1, 16, 2);

        // abort outside RUN is ignored
        @(negedge clk); mif.abort = 1'b1;
        @(negedge clk); mif.abort = 1'b0;
        chk("abort_done_done", int'(mif.done), 1);
        chk("abort_done_busy", int'(mif.busy), 0);

        mode = 1;
        run(16, -1, 0, 2);

        mode = 0;
        run(6, 5, 6, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
